rn_fc_mac_seq: RTL and testbench

//  Sequencer/datapath directly downstream of the FC weight-struct stage (rn_FC_struct).

---
 rtl/rn_fc_mac_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_rn_fc_mac_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rn_fc_mac_seq.sv
// FC MAC sequencer: walks rn_FC_struct neuron by neuron, dot-products activations with weights,
// adds bias, requantizes to int8 and writes the output buffer. Optional FC_RELU_EN clamps negatives to 0.
module rn_fc_mac_seq #(
    parameter int INPUTS_MAC = 6,
    parameter int ACC_W      = 24,
    parameter int OUT_SHIFT  = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    layer_done,
    output logic                    last_layer,
    input  logic [15:0]             iters_per_neuron,
    input  logic [7:0]              modulo,
    input  logic [7:0]              cant_neurons,
    input  logic [7:0]              last,
    input  logic [15:0]             of_offset,
    output logic                    next_layer,
    output logic                    next_neuron,
    output logic                    get_weight,
    input  logic [8*INPUTS_MAC-1:0] kernel_FC,
    input  logic [7:0]              bias_FC,
    input  logic                    struct_ready,
    output logic                    act_rd_en,
    output logic [15:0]             act_addr,
    input  logic [8*INPUTS_MAC-1:0] act_data,
    output logic                    of_we,
    output logic [15:0]             of_addr,
    output logic [7:0]              of_data,
    output logic [3:0]              dbg_state_o
);

    // Handshake: every strobe is a 1-cycle registered pulse; struct_ready is only sampled in the
    // cycle after it, and act_data is captured exactly one cycle after act_rd_en.
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_LAYER = 4'd1, S_HDR_WAIT = 4'd2, S_FETCH = 4'd3, S_WAIT = 4'd4,
        S_MAC = 4'd5, S_BIAS = 4'd6, S_WRITE = 4'd7, S_NEXT = 4'd8, S_DONE = 4'd9
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(127);

    state_t                   state_q;
    logic [15:0]              iters_q, iter_q;
    logic [7:0]               modulo_q, cant_q, n_q, bias_q;
    logic                     last_q, first_q, act_got_q;
    logic [15:0]              offset_q;
    logic [8*INPUTS_MAC-1:0]  w_q, a_q;
    logic signed [ACC_W-1:0]  acc_q;

    logic                     last_iter;
    logic signed [7:0]        wl, al;
    logic signed [15:0]       prod;
    logic signed [ACC_W-1:0]  mac_sum, acc_mac_d, acc_bias_d, shifted;
    logic [7:0]               res_d;
    logic [7:0]               hdr_cant;
    logic [15:0]              hdr_iters;
    logic                     hdr_last;

    assign dbg_state_o = state_q;
    assign hdr_cant    = first_q ? cant_neurons : cant_q;
    assign hdr_iters   = first_q ? iters_per_neuron : iters_q;
    assign hdr_last    = first_q ? (last != 8'd0) : last_q;

    always_comb begin
        last_iter = (iter_q == iters_q - 16'd1);
        wl        = '0;
        al        = '0;
        prod      = '0;
        mac_sum   = '0;
        for (int i = 0; i < INPUTS_MAC; i++) begin
            wl   = w_q[8*i +: 8];
            al   = a_q[8*i +: 8];
            prod = wl * al;
            if (!(last_iter && modulo_q != 8'd0 && 8'(i) >= modulo_q))
                mac_sum = mac_sum + {{(ACC_W-16){prod[15]}}, prod};
        end
        acc_mac_d  = acc_q + mac_sum;
        acc_bias_d = acc_q + {{(ACC_W-8){bias_q[7]}}, bias_q};
        shifted    = acc_bias_d >>> OUT_SHIFT;
        // Symmetric clamp to +/-127 so the result range is balanced around zero.
        if (shifted > SAT_HI)
            res_d = 8'h7F;
        else if (shifted < SAT_LO)
            res_d = 8'h81;
        else
            res_d = shifted[7:0];
`ifdef FC_RELU_EN
        if (res_d[7])
            res_d = 8'h00;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            busy        <= 1'b0;
            layer_done  <= 1'b0;
            last_layer  <= 1'b0;
            next_layer  <= 1'b0;
            next_neuron <= 1'b0;
            get_weight  <= 1'b0;
            act_rd_en   <= 1'b0;
            act_addr    <= '0;
            of_we       <= 1'b0;
            of_addr     <= '0;
            of_data     <= '0;
            iters_q     <= '0;
            iter_q      <= '0;
            modulo_q    <= '0;
            cant_q      <= '0;
            n_q         <= '0;
            bias_q      <= '0;
            last_q      <= 1'b0;
            first_q     <= 1'b0;
            act_got_q   <= 1'b0;
            offset_q    <= '0;
            w_q         <= '0;
            a_q         <= '0;
            acc_q       <= '0;
        end else begin
            next_layer  <= 1'b0;
            next_neuron <= 1'b0;
            get_weight  <= 1'b0;
            act_rd_en   <= 1'b0;
            of_we       <= 1'b0;
            layer_done  <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    busy       <= 1'b1;
                    first_q    <= 1'b1;
                    n_q        <= '0;
                    iter_q     <= '0;
                    acc_q      <= '0;
                    next_layer <= 1'b1;
                    state_q    <= S_LAYER;
                end
                S_LAYER: state_q <= S_HDR_WAIT;
                S_HDR_WAIT: if (struct_ready) begin
                    bias_q  <= bias_FC;
                    first_q <= 1'b0;
                    iter_q  <= '0;
                    if (first_q) begin
                        iters_q  <= iters_per_neuron;
                        modulo_q <= modulo;
                        cant_q   <= cant_neurons;
                        last_q   <= (last != 8'd0);
                        offset_q <= of_offset;
                    end
                    if (hdr_cant == 8'd0) begin
                        busy       <= 1'b0;
                        layer_done <= 1'b1;
                        last_layer <= hdr_last;
                        state_q    <= S_DONE;
                    end else if (hdr_iters == 16'd0) begin
                        state_q <= S_BIAS;
                    end else begin
                        get_weight <= 1'b1;
                        act_rd_en  <= 1'b1;
                        act_addr   <= '0;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    act_got_q <= 1'b0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    // The activation word is only valid in the first WAIT cycle.
                    if (!act_got_q) begin
                        a_q       <= act_data;
                        act_got_q <= 1'b1;
                    end
                    if (struct_ready) begin
                        w_q     <= kernel_FC;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_mac_d;
                    if (last_iter) begin
                        state_q <= S_BIAS;
                    end else begin
                        iter_q     <= iter_q + 16'd1;
                        act_addr   <= iter_q + 16'd1;
                        get_weight <= 1'b1;
                        act_rd_en  <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_BIAS: begin
                    acc_q   <= acc_bias_d;
                    of_data <= res_d;
                    of_addr <= offset_q + {8'd0, n_q};
                    of_we   <= 1'b1;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    next_neuron <= 1'b1;
                    state_q     <= S_NEXT;
                end
                S_NEXT: begin
                    acc_q  <= '0;
                    iter_q <= '0;
                    if (n_q + 8'd1 == cant_q) begin
                        busy       <= 1'b0;
                        layer_done <= 1'b1;
                        last_layer <= last_q;
                        state_q    <= S_DONE;
                    end else begin
                        n_q     <= n_q + 8'd1;
                        state_q <= S_HDR_WAIT;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rn_fc_mac_seq.sv
// Directed bench for rn_fc_mac_seq: two instances (OUT_SHIFT 0 and 7) share one struct/activation
// responder; every neuron write is scored against hand-computed values in an expected queue.
module tb_rn_fc_mac_seq;

    logic        clk, rst, start, struct_ready;
    logic [15:0] iters_per_neuron, of_offset;
    logic [7:0]  modulo, cant_neurons, last, bias_FC;
    logic [47:0] kernel_FC, act_data;

    logic        busy_0, layer_done_0, last_layer_0, next_layer_0, next_neuron_0, get_weight_0;
    logic        act_rd_en_0, of_we_0;
    logic [15:0] act_addr_0, of_addr_0;
    logic [7:0]  of_data_0;
    logic [3:0]  dbg_state_0;
    logic        busy_7, layer_done_7, last_layer_7, next_layer_7, next_neuron_7, get_weight_7;
    logic        act_rd_en_7, of_we_7;
    logic [15:0] act_addr_7, of_addr_7;
    logic [7:0]  of_data_7;
    logic [3:0]  dbg_state_7;

    rn_fc_mac_seq #(.INPUTS_MAC(6), .ACC_W(24), .OUT_SHIFT(0)) u_s0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_0), .layer_done(layer_done_0),
        .last_layer(last_layer_0), .iters_per_neuron(iters_per_neuron), .modulo(modulo),
        .cant_neurons(cant_neurons), .last(last), .of_offset(of_offset),
        .next_layer(next_layer_0), .next_neuron(next_neuron_0), .get_weight(get_weight_0),
        .kernel_FC(kernel_FC), .bias_FC(bias_FC), .struct_ready(struct_ready),
        .act_rd_en(act_rd_en_0), .act_addr(act_addr_0), .act_data(act_data),
        .of_we(of_we_0), .of_addr(of_addr_0), .of_data(of_data_0), .dbg_state_o(dbg_state_0));

    rn_fc_mac_seq #(.INPUTS_MAC(6), .ACC_W(24), .OUT_SHIFT(7)) u_s7 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_7), .layer_done(layer_done_7),
        .last_layer(last_layer_7), .iters_per_neuron(iters_per_neuron), .modulo(modulo),
        .cant_neurons(cant_neurons), .last(last), .of_offset(of_offset),
        .next_layer(next_layer_7), .next_neuron(next_neuron_7), .get_weight(get_weight_7),
        .kernel_FC(kernel_FC), .bias_FC(bias_FC), .struct_ready(struct_ready),
        .act_rd_en(act_rd_en_7), .act_addr(act_addr_7), .act_data(act_data),
        .of_we(of_we_7), .of_addr(of_addr_7), .of_data(of_data_7), .dbg_state_o(dbg_state_7));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_vec = 0, n_err = 0;
    int          ld_cnt, nn_cnt, gw_cnt, wr_cnt, nl_cnt;
    logic        last_seen;
    logic [31:0] exp_q[$];
    logic [7:0]  wv;
    logic [7:0]  av_tab[4];
    logic [7:0]  bias_tab[4];
    int          nidx, stall_n, st_cnt;
    logic        stall_arm, act_pend;
    logic [15:0] addr_pend;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rl(input logic [7:0] v);
`ifdef FC_RELU_EN
        return v[7] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    task automatic exp_push(input logic [15:0] addr, input logic [7:0] d0, input logic [7:0] d7);
        exp_q.push_back({addr, rl(d0), rl(d7)});
    endtask

    // struct + activation memory responder
    initial begin
        struct_ready = 1'b1;
        act_data     = 48'hA5A5_A5A5_A5A5;
        kernel_FC    = '0;
        bias_FC      = '0;
        nidx = 0; stall_n = 0; st_cnt = 0; stall_arm = 1'b0; act_pend = 1'b0; addr_pend = '0;
        forever begin
            @(posedge clk); #1;
            act_data  = act_pend ? {6{av_tab[addr_pend[1:0]]}} : 48'hA5A5_A5A5_A5A5;
            act_pend  = act_rd_en_0;
            addr_pend = act_addr_0;
            if (stall_arm) begin
                stall_arm    = 1'b0;
                struct_ready = 1'b0;
                st_cnt       = stall_n;
            end else if (st_cnt > 0) begin
                st_cnt--;
                if (st_cnt == 0) struct_ready = 1'b1;
            end
            if (get_weight_0 && stall_n > 0) stall_arm = 1'b1;
            if (next_neuron_0 && nidx < 3) nidx++;
            bias_FC   = bias_tab[nidx];
            kernel_FC = struct_ready ? {6{wv}} : 48'h3C3C_3C3C_3C3C;
        end
    end

    // scoreboard / monitor
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (layer_done_0) begin
                ld_cnt++;
                last_seen = last_layer_0;
                check_val("ld_sync", {31'd0, layer_done_7}, 32'd1);
            end
            if (next_neuron_0) nn_cnt++;
            if (get_weight_0) gw_cnt++;
            if (next_layer_0) nl_cnt++;
            if (of_we_0) begin
                wr_cnt++;
                check_val("we_sync", {31'd0, of_we_7}, 32'd1);
                check_val("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("of_addr", {16'd0, of_addr_0}, {16'd0, e[31:16]});
                    check_val("of_data_s0", {24'd0, of_data_0}, {24'd0, e[15:8]});
                    check_val("of_data_s7", {24'd0, of_data_7}, {24'd0, e[7:0]});
                end
            end
            if (busy_0 && !struct_ready)
                check_val("stall_state", {28'd0, dbg_state_0}, 32'd4);
        end
    end

    // driver
    task automatic run_layer(input logic [15:0] it, input logic [7:0] md, input logic [7:0] cn,
                             input logic [7:0] ls, input logic [15:0] off, input int stall,
                             input bit poke, input logic exp_last);
        int c;
        iters_per_neuron = it; modulo = md; cant_neurons = cn; last = ls; of_offset = off;
        stall_n = stall; nidx = 0; bias_FC = bias_tab[0];
        ld_cnt = 0; nn_cnt = 0; gw_cnt = 0; wr_cnt = 0; nl_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (poke) begin
            repeat (4) @(posedge clk);
            #1;
            start = 1'b1; of_offset = 16'h1234; cant_neurons = 8'd9; iters_per_neuron = 16'd7;
            @(posedge clk); #1 start = 1'b0;
        end
        c = 0;
        while (ld_cnt == 0 && c < 1000) begin
            @(posedge clk);
            c++;
        end
        check_val("ld_timeout", {31'd0, ld_cnt != 0}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check_val("ld_once", ld_cnt, 32'd1);
        check_val("nl_once", nl_cnt, 32'd1);
        check_val("wr_cnt", wr_cnt, {24'd0, cn});
        check_val("nn_cnt", nn_cnt, {24'd0, cn});
        check_val("gw_cnt", gw_cnt, 32'(int'(it) * int'(cn)));
        check_val("exp_q_empty", exp_q.size(), 32'd0);
        check_val("last_layer", {31'd0, last_seen}, {31'd0, exp_last});
        check_val("busy_idle", {31'd0, busy_0}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0;
        iters_per_neuron = '0; modulo = '0; cant_neurons = '0; last = '0; of_offset = '0;
        wv = 8'd0;
        for (int i = 0; i < 4; i++) begin av_tab[i] = 8'd0; bias_tab[i] = 8'd0; end
        ld_cnt = 0; nn_cnt = 0; gw_cnt = 0; wr_cnt = 0; nl_cnt = 0; last_seen = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", {31'd0, busy_0}, 32'd0);
        check_val("rst_we", {31'd0, of_we_0}, 32'd0);
        check_val("rst_state", {28'd0, dbg_state_0}, 32'd0);
        check_val("rst_odata", {24'd0, of_data_0}, 32'd0);
        check_val("rst_strobes", {28'd0, next_layer_0, next_neuron_0, get_weight_0, act_rd_en_0}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // 1: all-ones, 6 lanes
        wv = 8'd1; for (int i = 0; i < 4; i++) av_tab[i] = 8'd1; bias_tab[0] = 8'd0;
        exp_push(16'h0100, 8'h06, 8'h00);
        run_layer(16'd1, 8'd0, 8'd1, 8'd0, 16'h0100, 0, 1'b0, 1'b0);

        // 2: two iterations, modulo 2, bias -4 -> 28
        wv = 8'd2; for (int i = 0; i < 4; i++) av_tab[i] = 8'd2; bias_tab[0] = 8'hFC;
        exp_push(16'h0200, 8'h1C, 8'h00);
        run_layer(16'd2, 8'd2, 8'd1, 8'd0, 16'h0200, 0, 1'b0, 1'b0);

        // 3: positive and negative saturation
        wv = 8'd127; for (int i = 0; i < 4; i++) av_tab[i] = 8'd127; bias_tab[0] = 8'd127;
        exp_push(16'h0300, 8'h7F, 8'h7F);
        run_layer(16'd1, 8'd0, 8'd1, 8'd1, 16'h0300, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) av_tab[i] = 8'h80;
        exp_push(16'h0301, 8'h81, 8'h81);
        run_layer(16'd1, 8'd0, 8'd1, 8'd0, 16'h0301, 0, 1'b0, 1'b0);

        // 4: 3 neurons, address wrap, partial lanes, ignored restart and header change
        wv = 8'd3; for (int i = 0; i < 4; i++) av_tab[i] = 8'hFE;
        bias_tab[0] = 8'h0A; bias_tab[1] = 8'h9C; bias_tab[2] = 8'h32; bias_tab[3] = 8'h00;
        exp_push(16'hFFFF, 8'hF8, 8'hFF);
        exp_push(16'h0000, 8'h8A, 8'hFF);
        exp_push(16'h0001, 8'h20, 8'h00);
        run_layer(16'd1, 8'd3, 8'd3, 8'd0, 16'hFFFF, 0, 1'b1, 1'b0);

        // 5: struct_ready low 5 cycles per weight; per-address activations 1,2,3
        wv = 8'd1; av_tab[0] = 8'd1; av_tab[1] = 8'd2; av_tab[2] = 8'd3; av_tab[3] = 8'd0;
        bias_tab[0] = 8'd100;
        exp_push(16'h0500, 8'h7F, 8'h01);
        run_layer(16'd3, 8'd0, 8'd1, 8'd0, 16'h0500, 5, 1'b0, 1'b0);

        // 7: zero iterations -> bias only
        bias_tab[0] = 8'h80;
        exp_push(16'h0700, 8'h81, 8'hFF);
        run_layer(16'd0, 8'd0, 8'd1, 8'd0, 16'h0700, 0, 1'b0, 1'b0);

        // 6: reset mid-MAC aborts without layer_done
        wv = 8'd1; for (int i = 0; i < 4; i++) av_tab[i] = 8'd1; bias_tab[0] = 8'd0;
        iters_per_neuron = 16'd4; modulo = 8'd0; cant_neurons = 8'd2; last = 8'd1; of_offset = 16'h0600;
        stall_n = 0; nidx = 0; ld_cnt = 0; wr_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_busy", {31'd0, busy_0}, 32'd0);
        check_val("abort_state", {28'd0, dbg_state_0}, 32'd0);
        check_val("abort_outs", {29'd0, of_we_0, get_weight_0, act_rd_en_0}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_val("abort_no_ld", ld_cnt, 32'd0);
        check_val("abort_no_wr", wr_cnt, 32'd0);

        exp_push(16'h0100, 8'h06, 8'h00);
        run_layer(16'd1, 8'd0, 8'd1, 8'd0, 16'h0100, 0, 1'b0, 1'b0);

        // zero neurons: layer_done without writes
        run_layer(16'd1, 8'd0, 8'd0, 8'd5, 16'h0800, 0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
